// File: rtl/seq_alu_unit_if.sv
// seq_alu_unit_if
//   Request/response bundle for seq_alu_unit.
//   master : drives start, ALUOp, funct3, funct7b5, funct7b0, opb5, a, b;
//            observes busy, done, result, zero.
//   slave  : the ALU side of the same signals.
interface seq_alu_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       ALUOp;
  logic [2:0]       funct3;
  logic             funct7b5;
  logic             funct7b0;
  logic             opb5;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;

  modport master (
    output start, ALUOp, funct3, funct7b5, funct7b0, opb5, a, b,
    input  busy, done, result, zero
  );

  modport slave (
    input  start, ALUOp, funct3, funct7b5, funct7b0, opb5, a, b,
    output busy, done, result, zero
  );
endinterface

// File: rtl/seq_alu_unit.sv
// seq_alu_unit
//   Multi-cycle integer ALU. Single-cycle ops (add/sub/compare/logic and
//   zero-distance shifts) finish in one cycle; shifts walk one bit position
//   per cycle; multiply is a WIDTH-cycle shift-add. A one-cycle DONE state
//   presents done with the registered result.
//   Ports:
//     clk     : clock, rising edge
//     reset_n : asynchronous active-low reset
//     bus     : seq_alu_unit_if.slave (start/op/operands in, busy/done/result/zero out)
module seq_alu_unit #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic          clk,
  input  logic          reset_n,
  seq_alu_unit_if.slave bus
);

  localparam int SHW  = $clog2(WIDTH);
  localparam int CNTW = SHW + 1;

  localparam logic [CNTW-1:0]  CNT_ONE  = CNTW'(1);
  localparam logic [CNTW-1:0]  CNT_FULL = CNTW'(WIDTH);
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_MUL   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  // Map ALUOp/funct fields to an internal op code.
  function automatic logic [3:0] decode_op(
    input logic [1:0] alu_op,
    input logic [2:0] f3,
    input logic       f7b5,
    input logic       f7b0,
    input logic       ob5
  );
    logic [3:0] op;
    op = OP_ADD;
    case (alu_op)
      2'b00: op = OP_ADD;
      2'b01: op = OP_SUB;
      2'b10: begin
        case (f3)
          3'b000: begin
            if (MUL_EN && ob5 && f7b0) op = OP_MUL;
            else if (ob5 && f7b5)      op = OP_SUB;
            else                       op = OP_ADD;
          end
          3'b001: op = OP_SLL;
          3'b010: op = OP_SLT;
          3'b011: op = OP_SLTU;
          3'b100: op = OP_XOR;
          3'b101: op = f7b5 ? OP_SRA : OP_SRL;
          3'b110: op = OP_OR;
          3'b111: op = OP_AND;
          default: op = OP_ADD;
        endcase
      end
      default: op = OP_ADD;
    endcase
    return op;
  endfunction

  // Result of every op that completes in the start cycle. Shifts only reach
  // here with a zero distance, but the full shift is kept for clarity.
  function automatic logic [WIDTH-1:0] alu_single(
    input logic [3:0]       op,
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y
  );
    logic [WIDTH-1:0] r;
    logic [SHW-1:0]   sh;
    sh = y[SHW-1:0];
    r  = ZERO_W;
    case (op)
      OP_ADD:  r = x + y;
      OP_SUB:  r = x - y;
      OP_SLL:  r = x << sh;
      OP_SRL:  r = x >> sh;
      OP_SRA:  r = $signed(x) >>> sh;
      OP_SLT:  r = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
      OP_SLTU: r = {{(WIDTH-1){1'b0}}, (x < y)};
      OP_XOR:  r = x ^ y;
      OP_OR:   r = x | y;
      OP_AND:  r = x & y;
      default: r = x + y;
    endcase
    return r;
  endfunction

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [3:0]       op_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] acc_r;
  logic [CNTW-1:0]  cnt_r;
  logic [WIDTH-1:0] result_r;
  logic             zero_r;
  logic             busy_r;
  logic             done_r;

  logic [3:0]       op_dec_s;
  logic [SHW-1:0]   shamt_s;
  logic             is_shift_s;
  logic [WIDTH-1:0] single_res_s;
  logic [WIDTH-1:0] shift_step_s;
  logic [WIDTH-1:0] mul_acc_nxt_s;

  assign op_dec_s     = decode_op(bus.ALUOp, bus.funct3, bus.funct7b5, bus.funct7b0, bus.opb5);
  assign shamt_s      = bus.b[SHW-1:0];
  assign is_shift_s   = (op_dec_s == OP_SLL) || (op_dec_s == OP_SRL) || (op_dec_s == OP_SRA);
  assign single_res_s = alu_single(op_dec_s, bus.a, bus.b);
  // Add the shifted multiplicand when the current multiplier LSB is set.
  assign mul_acc_nxt_s = acc_r + (b_r[0] ? a_r : ZERO_W);

  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.result = result_r;
  assign bus.zero   = zero_r;

  // One-bit shift step for the iterative shifter; sra refills with the sign bit.
  always_comb begin
    shift_step_s = a_r;
    case (op_r)
      OP_SLL:  shift_step_s = {a_r[WIDTH-2:0], 1'b0};
      OP_SRL:  shift_step_s = {1'b0, a_r[WIDTH-1:1]};
      OP_SRA:  shift_step_s = {a_r[WIDTH-1], a_r[WIDTH-1:1]};
      default: shift_step_s = a_r;
    endcase
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          if (is_shift_s && (shamt_s != {SHW{1'b0}})) state_nxt_s = ST_SHIFT;
          else if (op_dec_s == OP_MUL)                 state_nxt_s = ST_MUL;
          else                                         state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (cnt_r == CNT_ONE) state_nxt_s = ST_DONE;
        else                  state_nxt_s = ST_SHIFT;
      end
      ST_MUL: begin
        if (cnt_r == CNT_ONE) state_nxt_s = ST_DONE;
        else                  state_nxt_s = ST_MUL;
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, operand latches, iteration datapath and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= ST_IDLE;
      op_r     <= OP_ADD;
      a_r      <= ZERO_W;
      b_r      <= ZERO_W;
      acc_r    <= ZERO_W;
      cnt_r    <= {CNTW{1'b0}};
      result_r <= ZERO_W;
      zero_r   <= 1'b1;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != ST_IDLE);
      done_r  <= (state_nxt_s == ST_DONE);
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            op_r  <= op_dec_s;
            a_r   <= bus.a;
            b_r   <= bus.b;
            acc_r <= ZERO_W;
            cnt_r <= (op_dec_s == OP_MUL) ? CNT_FULL : {1'b0, shamt_s};
            if (state_nxt_s == ST_DONE) begin
              result_r <= single_res_s;
              zero_r   <= (single_res_s == ZERO_W);
            end
          end
        end
        ST_SHIFT: begin
          a_r   <= shift_step_s;
          cnt_r <= cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            result_r <= shift_step_s;
            zero_r   <= (shift_step_s == ZERO_W);
          end
        end
        ST_MUL: begin
          acc_r <= mul_acc_nxt_s;
          a_r   <= {a_r[WIDTH-2:0], 1'b0};
          b_r   <= {1'b0, b_r[WIDTH-1:1]};
          cnt_r <= cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            result_r <= mul_acc_nxt_s;
            zero_r   <= (mul_acc_nxt_s == ZERO_W);
          end
        end
        ST_DONE: begin
          op_r <= op_r;
        end
        default: begin
          op_r <= op_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu_unit.sv
// tb_seq_alu_unit
//   Directed-vector bench. Two instances share the same stimulus: one with
//   the multiplier enabled, one with multiply decoded as add.
module tb_seq_alu_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  alu_op;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic        funct7b0;
  logic        opb5;
  logic [31:0] a;
  logic [31:0] b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_alu_unit_if #(.WIDTH(32)) ifa ();
  seq_alu_unit_if #(.WIDTH(32)) ifb ();

  assign ifa.start    = start;
  assign ifa.ALUOp    = alu_op;
  assign ifa.funct3   = funct3;
  assign ifa.funct7b5 = funct7b5;
  assign ifa.funct7b0 = funct7b0;
  assign ifa.opb5     = opb5;
  assign ifa.a        = a;
  assign ifa.b        = b;
  assign ifb.start    = start;
  assign ifb.ALUOp    = alu_op;
  assign ifb.funct3   = funct3;
  assign ifb.funct7b5 = funct7b5;
  assign ifb.funct7b0 = funct7b0;
  assign ifb.opb5     = opb5;
  assign ifb.a        = a;
  assign ifb.b        = b;

  seq_alu_unit #(.WIDTH(32), .MUL_EN(1'b1)) dut_mul (
    .clk(clk), .reset_n(reset_n), .bus(ifa.slave)
  );
  seq_alu_unit #(.WIDTH(32), .MUL_EN(1'b0)) dut_nomul (
    .clk(clk), .reset_n(reset_n), .bus(ifb.slave)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic [1:0] op, input logic [2:0] f3, input logic f7b5,
                             input logic f7b0, input logic ob5, input logic [31:0] av,
                             input logic [31:0] bv);
    @(negedge clk);
    alu_op = op; funct3 = f3; funct7b5 = f7b5; funct7b0 = f7b0; opb5 = ob5;
    a = av; b = bv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((ifa.busy || ifb.busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("idle", {63'd0, (ifa.busy | ifb.busy)}, 64'd0);
  endtask

  // Start one op, measure latency (cycles after start cycle) on the chosen unit.
  task automatic do_op(input bit unit, input string tag, input logic [1:0] op,
                       input logic [2:0] f3, input logic f7b5, input logic f7b0,
                       input logic ob5, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] exp_res, input int exp_lat);
    int lat;
    int busyc;
    pulse_start(op, f3, f7b5, f7b0, ob5, av, bv);
    lat   = 1;
    busyc = 0;
    while (1) begin
      if (unit ? ifb.busy : ifa.busy) busyc++;
      if (unit ? ifb.done : ifa.done) break;
      if (lat >= 100) break;
      @(negedge clk);
      lat++;
    end
    check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check_eq({tag, "_res"}, {32'd0, (unit ? ifb.result : ifa.result)}, {32'd0, exp_res});
    check_eq({tag, "_zero"}, {63'd0, (unit ? ifb.zero : ifa.zero)}, {63'd0, (exp_res == 32'd0)});
    check_eq({tag, "_busy"}, 64'(busyc), 64'(exp_lat));
    @(negedge clk);
    check_eq({tag, "_pulse"}, {63'd0, (unit ? ifb.done : ifa.done)}, 64'd0);
    wait_idle();
  endtask

  initial begin
    int lat;
    int nd;
    reset_n = 1'b0;
    start = 1'b0; alu_op = 2'b00; funct3 = 3'b000; funct7b5 = 1'b0;
    funct7b0 = 1'b0; opb5 = 1'b0; a = 32'd0; b = 32'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", {63'd0, ifa.busy}, 64'd0);
    check_eq("rst_done", {63'd0, ifa.done}, 64'd0);
    check_eq("rst_result", {32'd0, ifa.result}, 64'd0);
    check_eq("rst_zero", {63'd0, ifa.zero}, 64'd1);
    check_eq("rst_zero_b", {63'd0, ifb.zero}, 64'd1);
    reset_n = 1'b1;
    @(negedge clk);

    //    unit tag          ALUOp  f3     f7b5  f7b0  opb5  a              b              result         lat
    do_op(0, "sub_r",     2'b10, 3'b000, 1'b1, 1'b0, 1'b1, 32'd5,         32'd7,         32'hFFFFFFFE,  1);
    do_op(0, "addi",      2'b10, 3'b000, 1'b1, 1'b0, 1'b0, 32'd5,         32'd7,         32'd12,        1);
    do_op(0, "add_wrap",  2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF,  32'd1,         32'd0,         1);
    do_op(0, "sub_op01",  2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 32'd10,        32'd3,         32'd7,         1);
    do_op(0, "rsv_add",   2'b11, 3'b111, 1'b1, 1'b0, 1'b1, 32'd2,         32'd3,         32'd5,         1);
    do_op(0, "sra4",      2'b10, 3'b101, 1'b1, 1'b0, 1'b1, 32'h80000000,  32'd4,         32'hF8000000,  5);
    do_op(0, "srl4_hi",   2'b10, 3'b101, 1'b0, 1'b0, 1'b1, 32'h80000000,  32'h24,        32'h08000000,  5);
    do_op(0, "sll_sh0",   2'b10, 3'b001, 1'b0, 1'b0, 1'b1, 32'h1234,      32'd32,        32'h1234,      1);
    do_op(0, "slt",       2'b10, 3'b010, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF,  32'd1,         32'd1,         1);
    do_op(0, "sltu",      2'b10, 3'b011, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF,  32'd1,         32'd0,         1);
    do_op(0, "xor",       2'b10, 3'b100, 1'b0, 1'b0, 1'b1, 32'hF0F000FF,  32'h0FF00F0F,  32'hFF000FF0,  1);
    do_op(0, "or",        2'b10, 3'b110, 1'b0, 1'b0, 1'b1, 32'hF0F000FF,  32'h0FF00F0F,  32'hFFF00FFF,  1);
    do_op(0, "and",       2'b10, 3'b111, 1'b0, 1'b0, 1'b1, 32'hF0F000FF,  32'h0FF00F0F,  32'h00F0000F,  1);
    do_op(0, "mul",       2'b10, 3'b000, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFF,  32'd3,         32'hFFFFFFFD,  33);
    do_op(0, "mul_7x6",   2'b10, 3'b000, 1'b1, 1'b1, 1'b1, 32'd7,         32'd6,         32'd42,        33);
    do_op(1, "nomul_add", 2'b10, 3'b000, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFF,  32'd3,         32'd2,         1);

    // Long shift with start pulses mid-operation and in the DONE cycle.
    pulse_start(2'b10, 3'b001, 1'b0, 1'b0, 1'b1, 32'd1, 32'd31);
    lat = 1;
    @(negedge clk);
    lat++;
    alu_op = 2'b00; a = 32'd1; b = 32'd1;
    start = 1'b1;
    @(negedge clk);
    lat++;
    start = 1'b0;
    while (!ifa.done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check_eq("ign_lat", 64'(lat), 64'd32);
    check_eq("ign_res", {32'd0, ifa.result}, 64'h80000000);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("ign_done_drop", {63'd0, ifa.done}, 64'd0);
    nd = 0;
    repeat (5) begin
      @(negedge clk);
      if (ifa.done) nd++;
    end
    check_eq("ign_no_second_done", 64'(nd), 64'd0);
    check_eq("ign_idle", {63'd0, ifa.busy}, 64'd0);
    check_eq("ign_res_hold", {32'd0, ifa.result}, 64'h80000000);

    // Reset in the middle of a multiply.
    pulse_start(2'b10, 3'b000, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 32'd3);
    repeat (9) @(negedge clk);
    check_eq("mid_mul_busy", {63'd0, ifa.busy}, 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("arst_busy", {63'd0, ifa.busy}, 64'd0);
    check_eq("arst_done", {63'd0, ifa.done}, 64'd0);
    check_eq("arst_result", {32'd0, ifa.result}, 64'd0);
    check_eq("arst_zero", {63'd0, ifa.zero}, 64'd1);
    @(negedge clk);
    reset_n = 1'b1;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (ifa.done || ifa.busy) nd++;
    end
    check_eq("arst_no_done", 64'(nd), 64'd0);

    do_op(0, "post_rst",  2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'd2,         32'd3,         32'd5,         1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_alu_unit.md
SEQ_ALU_UNIT -- requirements
Module: seq_alu_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; legal values 8, 16, 32, 64.
REQ-002 Parameter MUL_EN, default 1; 1 enables the iterative multiply, 0 decodes multiply as add.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request; accepted only when busy=0.
REQ-006 ALUOp  input  2  00 add, 01 sub, 10 decode funct3, 11 reserved (add).
REQ-007 funct3  input  3  instruction funct3.
REQ-008 funct7b5  input  1  instruction bit 30 (sub/sra select).
REQ-009 funct7b0  input  1  instruction bit 25 (M-extension select).
REQ-010 opb5  input  1  opcode bit 5 (1 = R-type).
REQ-011 a, b  input  WIDTH  operands.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse; result valid.
REQ-014 result  output  WIDTH  registered result; held until next accepted start.
REQ-015 zero  output  1  registered, result == 0.

Function
REQ-016 Decode at start, ALUOp=10: funct3 000 -> mul if MUL_EN & opb5 & funct7b0, else sub if opb5 & funct7b5, else add; 001 sll; 010 slt (signed); 011 sltu; 100 xor; 101 sra if funct7b5 else srl; 110 or; 111 and.
REQ-017 On accepted start, a, b and decoded op latch internally; later input changes ignored until done.
REQ-018 FSM states IDLE, SHIFT, MUL, DONE; reset state IDLE.
REQ-019 IDLE & start: shift with shamt>0 -> SHIFT; mul -> MUL; all other ops, and shifts with shamt=0 -> DONE with result computed in that edge.
REQ-020 shamt = b[log2(WIDTH)-1:0]; upper bits of b ignored.
REQ-021 SHIFT: one bit position per cycle, shamt cycles, then DONE; sra replicates sign bit each step; latency shamt+1 cycles.
REQ-022 MUL: shift-add, one multiplier bit per cycle, exactly WIDTH cycles, then DONE; result = low WIDTH bits of a*b (sign-agnostic); latency WIDTH+1.
REQ-023 Single-cycle ops: done high in the cycle after the start cycle (latency 1).
REQ-024 DONE: done=1, busy=1 for exactly one cycle, then IDLE; next start accepted no earlier than the following cycle.
REQ-025 start while busy=1 (including the DONE cycle) is ignored, not queued.
REQ-026 add/sub wrap modulo 2^WIDTH; no overflow flag.
REQ-027 slt/sltu result = {WIDTH-1 zeros, compare bit}.
REQ-028 result and zero update only in the cycle entering DONE; otherwise hold.

Reset
REQ-029 reset_n=0 at any time, including mid-SHIFT/MUL, forces IDLE immediately; busy=0, done=0, result=0, zero=1; operation discarded.
REQ-030 After reset_n release, first accepted start behaves as from power-up.

Verification (WIDTH=32)
REQ-031 ALUOp=10, funct3=000, opb5=1, funct7b5=1, a=5, b=7, start -> next cycle done=1, result=0xFFFFFFFE, zero=0.
REQ-032 ALUOp=10, funct3=101, funct7b5=1, a=0x80000000, b=4 -> done 5 cycles after start, result=0xF8000000; busy high cycles 1-5.
REQ-033 ALUOp=10, funct3=000, opb5=1, funct7b0=1, a=0xFFFFFFFF, b=3 -> done 33 cycles after start, result=0xFFFFFFFD; repeat with MUL_EN=0 -> latency 1, result=0x00000002.
REQ-034 funct3=001, b=32 (shamt 0), a=0x1234 -> latency 1, result=0x1234; then start pulsed during busy of a long op -> ignored, no second done.
REQ-035 Mul in progress, reset_n low at cycle 10 -> busy=0, done=0, result=0, zero=1 asynchronously; no done after release.
REQ-036 ALUOp=10, funct3=010 vs 011, a=0xFFFFFFFF, b=1 -> slt result=1, sltu result=0, zero=1 on sltu.
